// File: rtl/cpu_uart_tx_mmio_if.sv
// CPU data-bus port of the memory-mapped UART transmitter: address, store data,
// byte enables and the combinational load data returned by the peripheral.
interface cpu_uart_tx_mmio_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wenable;
    logic [31:0] rdata;

    modport master (
        output addr,
        output wdata,
        output wenable,
        input  rdata
    );

    modport slave (
        input  addr,
        input  wdata,
        input  wenable,
        output rdata
    );
endinterface

// File: rtl/cpu_uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: stores to TXDATA fill a FIFO that a
// serializer drains onto tx; STATUS is readable in the same cycle.
module cpu_uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    cpu_uart_tx_mmio_if.slave   bus,
    output logic                tx,
    output logic                irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] bit_cnt_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_next;
    logic [7:0]       shift;
    logic [7:0]       shift_next;
    logic             tx_next;
    logic             bit_done;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             overflow;

    logic             hit;
    logic [1:0]       offset;
    logic             full;
    logic             empty;
    logic             busy;
    logic             push_req;
    logic             push;
    logic             pop;
    logic             clear_ovf;
    logic             unused_bits;

    assign hit       = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign offset    = bus.addr[3:2];
    assign full      = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign busy      = (state != IDLE) || !empty;
    assign irq       = empty && (state == IDLE);
    assign push_req  = hit && (offset == 2'd0) && bus.wenable[0];
    assign push      = push_req && !full;
    assign pop       = (state == IDLE) && !empty;
    assign clear_ovf = hit && (offset == 2'd1) && bus.wenable[0] && bus.wdata[3];
    assign bit_done  = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));

    assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:8], bus.wenable[3:1]};

    always_comb begin
        bus.rdata = 32'd0;
        if (hit && (offset == 2'd1)) begin
            bus.rdata = {28'd0, overflow, busy, empty, full};
        end
    end

    // A push while full is lost even if the serializer pops in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
            if (push_req && full) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            tx      <= tx_next;
        end
    end

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_next   = START;
                    shift_next   = mem[rd_ptr];
                    bit_cnt_next = '0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                    bit_idx_next = '0;
                end else begin
                    bit_cnt_next = bit_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    bit_cnt_next = '0;
                    shift_next   = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_next   = IDLE;
                    bit_cnt_next = '0;
                end else begin
                    bit_cnt_next = bit_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // tx is registered, so it is derived from where the FSM is about to be.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_cpu_uart_tx_mmio.sv
// Bench for cpu_uart_tx_mmio: a byte-queue/frame-timeline model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_cpu_uart_tx_mmio;

    localparam int          CPB         = 4;
    localparam int          DEPTH       = 8;
    localparam logic [31:0] BASE        = 32'h8000_0000;
    localparam logic [31:0] STATUS_ADDR = 32'h8000_0004;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic tx;
    logic irq;

    cpu_uart_tx_mmio_if bus();

    cpu_uart_tx_mmio #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave),
        .tx   (tx),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: queued bytes, and for the frame in flight its byte and cycle position.
    logic [7:0] m_q[$];
    bit         m_active = 1'b0;
    int         m_pos    = 0;
    logic [7:0] m_cur    = 8'd0;
    bit         m_ovf    = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model_step
        bit was_full;
        bit do_pop;
        bit hit;
        int off;
        if (!rst_n) begin
            m_q.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_cur    = 8'd0;
            m_ovf    = 1'b0;
        end else begin
            hit      = (bus.addr[31:4] == BASE[31:4]);
            off      = int'(bus.addr[3:2]);
            was_full = (m_q.size() == DEPTH);
            do_pop   = !m_active && (m_q.size() != 0);
            if (m_active) begin
                m_pos++;
                if (m_pos == 10 * CPB) m_active = 1'b0;
            end
            if (do_pop) begin
                m_cur    = m_q.pop_front();
                m_active = 1'b1;
                m_pos    = 0;
            end
            if (hit && off == 0 && bus.wenable[0]) begin
                if (was_full) m_ovf = 1'b1;
                else m_q.push_back(bus.wdata[7:0]);
            end
            if (hit && off == 1 && bus.wenable[0] && bus.wdata[3]) m_ovf = 1'b0;
        end
    end

    function automatic logic model_tx();
        int k;
        if (!m_active) return 1'b1;
        k = m_pos / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_cur[k-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [31:0] a);
        bit empty;
        bit busy;
        bit full;
        if (a[31:4] != BASE[31:4] || a[3:2] != 2'd1) return 32'd0;
        empty = (m_q.size() == 0);
        full  = (m_q.size() == DEPTH);
        busy  = m_active || !empty;
        return {28'd0, m_ovf, busy, empty, full};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #2;
            check_output("tx_model", {31'd0, tx}, {31'd0, model_tx()});
            check_output("irq_model", {31'd0, irq}, {31'd0, (m_q.size() == 0) && !m_active});
            check_output("rdata_model", bus.rdata, model_rdata(bus.addr));
        end
    end

    // Independent line receiver sampling mid-bit.
    logic [7:0] rx_q[$];
    initial begin
        logic [7:0] rb;
        forever begin
            @(negedge tx);
            if (rst_n) begin
                repeat (CPB / 2) @(posedge clk);
                for (int b = 0; b < 8; b++) begin
                    repeat (CPB) @(posedge clk);
                    #1;
                    rb[b] = tx;
                end
                repeat (CPB) @(posedge clk);
                rx_q.push_back(rb);
            end
        end
    end

    task automatic bus_idle();
        bus.addr    = STATUS_ADDR;
        bus.wdata   = 32'd0;
        bus.wenable = 4'd0;
    endtask

    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        @(negedge clk);
        bus.addr    = a;
        bus.wdata   = d;
        bus.wenable = w;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] expected);
        @(negedge clk);
        bus.addr    = a;
        bus.wdata   = 32'd0;
        bus.wenable = 4'd0;
        #1;
        check_output(name, bus.rdata, expected);
    endtask

    logic frame_a5 [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic samp [100];

    initial begin
        int first_low;
        bus_idle();
        repeat (3) @(negedge clk);
        check_output("reset_tx", {31'd0, tx}, 32'd1);
        check_output("reset_irq", {31'd0, irq}, 32'd1);
        read_check("reset_status", STATUS_ADDR, 32'h2);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte 0xA5
        apply_stimulus(BASE, 32'h0000_00A5, 4'b0001);
        @(negedge clk);
        bus_idle();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            check_output("a5_tx_bit", {31'd0, tx}, {31'd0, frame_a5[i / CPB]});
            check_output("a5_irq_low", {31'd0, irq}, 32'd0);
        end
        @(posedge clk);
        #1;
        check_output("a5_idle_tx", {31'd0, tx}, 32'd1);
        check_output("a5_idle_irq", {31'd0, irq}, 32'd1);
        check_output("a5_rx_count", rx_q.size(), 32'd1);
        if (rx_q.size() > 0) check_output("a5_rx_byte", {24'd0, rx_q[0]}, 32'hA5);
        read_check("a5_status", STATUS_ADDR, 32'h2);

        // Asynchronous reset mid-frame
        apply_stimulus(BASE, 32'h0000_003C, 4'b0001);
        @(negedge clk);
        bus_idle();
        repeat (15) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_output("midreset_tx", {31'd0, tx}, 32'd1);
        check_output("midreset_irq", {31'd0, irq}, 32'd1);
        check_output("midreset_status", bus.rdata, 32'h2);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        rx_q.delete();

        // Back-to-back frames with one idle cycle between them
        apply_stimulus(BASE, 32'h0000_0041, 4'b0001);
        apply_stimulus(BASE, 32'h0000_0042, 4'b0001);
        for (int j = 0; j < 100; j++) begin
            @(posedge clk);
            #1;
            samp[j] = tx;
            if (j == 0) bus_idle();
        end
        first_low = -1;
        for (int j = 36; j < 100; j++) begin
            if (first_low < 0 && samp[j] == 1'b0) first_low = j;
        end
        check_output("b2b_first_start", {31'd0, samp[0]}, 32'd0);
        check_output("b2b_gap_idle", {31'd0, samp[40]}, 32'd1);
        check_output("b2b_second_start", first_low, 32'd41);
        check_output("b2b_rx_count", rx_q.size(), 32'd2);
        if (rx_q.size() == 2) begin
            check_output("b2b_rx0", {24'd0, rx_q[0]}, 32'h41);
            check_output("b2b_rx1", {24'd0, rx_q[1]}, 32'h42);
        end

        // Address decode and byte-lane filtering
        apply_stimulus(32'h8000_0010, 32'h0000_005A, 4'b0001);
        apply_stimulus(32'h8000_0008, 32'h0000_005A, 4'b0001);
        apply_stimulus(BASE, 32'h0000_005A, 4'b1110);
        read_check("decode_rd_10", 32'h8000_0010, 32'h0);
        read_check("decode_rd_08", 32'h8000_0008, 32'h0);
        read_check("decode_rd_txdata", BASE, 32'h0);
        read_check("decode_status", STATUS_ADDR, 32'h2);
        repeat (10) @(negedge clk);
        check_output("decode_tx_idle", {31'd0, tx}, 32'd1);
        check_output("decode_irq", {31'd0, irq}, 32'd1);
        rx_q.delete();

        // Overflow: ten consecutive stores, the tenth is dropped
        for (int b = 0; b < 10; b++) begin
            apply_stimulus(BASE, 32'h0000_0011 + b, 4'b0001);
        end
        read_check("ovf_status", STATUS_ADDR, 32'hD);
        apply_stimulus(STATUS_ADDR, 32'h0000_0008, 4'b0001);
        read_check("ovf_cleared", STATUS_ADDR, 32'h5);
        bus_idle();

        // Drain
        repeat (9 * 41 + 20) @(negedge clk);
        check_output("drain_rx_count", rx_q.size(), 32'd9);
        for (int b = 0; b < 9; b++) begin
            if (b < rx_q.size()) check_output("drain_rx_byte", {24'd0, rx_q[b]}, 32'h11 + b);
        end
        read_check("drain_status", STATUS_ADDR, 32'h2);
        check_output("drain_irq", {31'd0, irq}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
